// File: rtl/common.sv
// Shared register map, read masks, bus/envelope types and the channel mixer helper for ay_psg.
package common;

    localparam logic [3:0] PSG_R_TONE_A_LO = 4'd0;
    localparam logic [3:0] PSG_R_TONE_A_HI = 4'd1;
    localparam logic [3:0] PSG_R_TONE_B_LO = 4'd2;
    localparam logic [3:0] PSG_R_TONE_B_HI = 4'd3;
    localparam logic [3:0] PSG_R_TONE_C_LO = 4'd4;
    localparam logic [3:0] PSG_R_TONE_C_HI = 4'd5;
    localparam logic [3:0] PSG_R_NOISE     = 4'd6;
    localparam logic [3:0] PSG_R_MIXER     = 4'd7;
    localparam logic [3:0] PSG_R_AMP_A     = 4'd8;
    localparam logic [3:0] PSG_R_AMP_B     = 4'd9;
    localparam logic [3:0] PSG_R_AMP_C     = 4'd10;
    localparam logic [3:0] PSG_R_ENV_LO    = 4'd11;
    localparam logic [3:0] PSG_R_ENV_HI    = 4'd12;
    localparam logic [3:0] PSG_R_ENV_SHAPE = 4'd13;

    // Implemented bits per register; unimplemented bits store and read back as 0.
    localparam logic [7:0] PSG_REG_MASK [16] = '{
        8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F, 8'hFF,
        8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF
    };

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'b00,
        BUS_READ  = 2'b01,
        BUS_WRITE = 2'b10,
        BUS_LATCH = 2'b11
    } bus_op_t;

    typedef enum logic {ENV_RUN, ENV_HOLD} env_state_t;

    typedef struct packed {
        logic cont;
        logic att;
        logic alt;
        logic hold;
    } env_shape_t;

    function automatic logic [3:0] psg_chan_level(
        input logic       i_tone,
        input logic       i_noise,
        input logic       i_tone_off,
        input logic       i_noise_off,
        input logic [4:0] i_amp,
        input logic [3:0] i_env
    );
        logic w_gate;
        w_gate = (i_tone | i_tone_off) & (i_noise | i_noise_off);
        return w_gate ? (i_amp[4] ? i_env : i_amp[3:0]) : 4'd0;
    endfunction

endpackage

// File: rtl/psg_tone.sv
// One tone channel: 12-bit period counter stepping on tick8, square output toggles on each wrap.
module psg_tone (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        i_tick,
    input  logic [11:0] i_period,
    output logic        o_tone
);

    logic [11:0] r_cnt;
    logic        r_tone;
    logic [11:0] w_limit;
    logic [12:0] w_next;

    assign w_limit = (i_period == 12'd0) ? 12'd1 : i_period;
    assign w_next  = {1'b0, r_cnt} + 13'd1;

    // Compare with >= so a period shortened below the running count wraps on the next tick.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else if (i_tick) begin
            if (w_next >= {1'b0, w_limit}) begin
                r_cnt  <= '0;
                r_tone <= ~r_tone;
            end else begin
                r_cnt <= w_next[11:0];
            end
        end
    end

    assign o_tone = r_tone;

endmodule

// File: rtl/ay_psg.sv
// AY-3-8912-compatible PSG: BC1/BDIR bus responder, 16-register file, three tones, noise and
// envelope generators, and registered per-channel 4-bit amplitude codes.
module ay_psg
    import common::*;
(
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ck35,
    input  logic       bdir,
    input  logic       bc1,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic [3:0] ch_a,
    output logic [3:0] ch_b,
    output logic [3:0] ch_c
);

    logic [7:0] r_regs [16];
    logic [3:0] r_addr;
    logic       r_sel;
    logic       r_armed;
    bus_op_t    r_prev_op;
    bus_op_t    w_op;
    logic       w_wr;
    logic       w_env_restart;

    assign w_op          = bus_op_t'({bdir, bc1});
    assign w_wr          = r_armed && r_sel && (w_op == BUS_WRITE);
    assign w_env_restart = w_wr && (r_addr == PSG_R_ENV_SHAPE) && (r_prev_op != BUS_WRITE);

    // r_armed keeps a bus cycle that straddles reset release from acting until the bus idles.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register file is flops, not RAM, so it takes the reset like any other state.
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
            r_addr    <= '0;
            r_sel     <= 1'b1;
            r_armed   <= 1'b0;
            r_prev_op <= BUS_IDLE;
            q         <= 8'hFF;
        end else begin
            r_prev_op <= w_op;
            q         <= 8'hFF;
            if (w_op == BUS_IDLE) r_armed <= 1'b1;
            if (r_armed) begin
                case (w_op)
                    BUS_LATCH: begin
                        r_addr <= d[3:0];
                        r_sel  <= (d[7:4] == 4'd0);
                    end
                    BUS_WRITE: if (w_wr) r_regs[r_addr] <= d & PSG_REG_MASK[r_addr];
                    BUS_READ:  if (r_sel) q <= r_regs[r_addr];
                    default: ;
                endcase
            end
        end
    end

    logic [3:0] r_pre;
    logic       r_half;
    logic       w_tick8;
    logic       w_tick16;

    assign w_tick8  = ck35 && (r_pre == 4'hF);
    assign w_tick16 = w_tick8 && r_half;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_half <= 1'b0;
        end else begin
            if (ck35)    r_pre  <= r_pre + 4'd1;
            if (w_tick8) r_half <= ~r_half;
        end
    end

    logic w_tone_a, w_tone_b, w_tone_c;

    psg_tone u_tone_a (
        .clk28    (clk28),
        .rst_n    (rst_n),
        .i_tick   (w_tick8),
        .i_period ({r_regs[PSG_R_TONE_A_HI][3:0], r_regs[PSG_R_TONE_A_LO]}),
        .o_tone   (w_tone_a)
    );

    psg_tone u_tone_b (
        .clk28    (clk28),
        .rst_n    (rst_n),
        .i_tick   (w_tick8),
        .i_period ({r_regs[PSG_R_TONE_B_HI][3:0], r_regs[PSG_R_TONE_B_LO]}),
        .o_tone   (w_tone_b)
    );

    psg_tone u_tone_c (
        .clk28    (clk28),
        .rst_n    (rst_n),
        .i_tick   (w_tick8),
        .i_period ({r_regs[PSG_R_TONE_C_HI][3:0], r_regs[PSG_R_TONE_C_LO]}),
        .o_tone   (w_tone_c)
    );

    logic [4:0]  r_noise_cnt;
    logic [16:0] r_lfsr;
    logic [4:0]  w_noise_per;
    logic [5:0]  w_noise_next;

    assign w_noise_per  = (r_regs[PSG_R_NOISE][4:0] == 5'd0) ? 5'd1 : r_regs[PSG_R_NOISE][4:0];
    assign w_noise_next = {1'b0, r_noise_cnt} + 6'd1;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_noise_cnt <= '0;
            r_lfsr      <= 17'h1;
        end else if (w_tick16) begin
            if (w_noise_next >= {1'b0, w_noise_per}) begin
                r_noise_cnt <= '0;
                r_lfsr      <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
            end else begin
                r_noise_cnt <= w_noise_next[4:0];
            end
        end
    end

    logic [15:0] r_env_cnt;
    logic [3:0]  r_env_pos;
    logic        r_env_up;
    env_state_t  r_env_state;
    env_shape_t  w_shape;
    logic [15:0] w_env_per;
    logic [16:0] w_env_next;
    logic        w_env_wrap;
    logic [3:0]  w_env_lvl;

    assign w_shape    = env_shape_t'(r_regs[PSG_R_ENV_SHAPE][3:0]);
    assign w_env_per  = ({r_regs[PSG_R_ENV_HI], r_regs[PSG_R_ENV_LO]} == 16'd0) ? 16'd1
                      : {r_regs[PSG_R_ENV_HI], r_regs[PSG_R_ENV_LO]};
    assign w_env_next = {1'b0, r_env_cnt} + 17'd1;
    assign w_env_wrap = w_env_next >= {1'b0, w_env_per};
    assign w_env_lvl  = r_env_up ? r_env_pos : (4'hF - r_env_pos);

    // A shape write restarts the ramp and swallows any coincident tick.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_env_cnt   <= '0;
            r_env_pos   <= '0;
            r_env_up    <= 1'b1;
            r_env_state <= ENV_HOLD;
        end else if (w_env_restart) begin
            r_env_cnt   <= '0;
            r_env_pos   <= '0;
            r_env_up    <= d[2];
            r_env_state <= ENV_RUN;
        end else if (w_tick16) begin
            r_env_cnt <= w_env_wrap ? 16'd0 : w_env_next[15:0];
            if (w_env_wrap && (r_env_state == ENV_RUN)) begin
                if (r_env_pos != 4'hF) begin
                    r_env_pos <= r_env_pos + 4'd1;
                end else if (!w_shape.cont) begin
                    r_env_pos   <= '0;
                    r_env_up    <= 1'b1;
                    r_env_state <= ENV_HOLD;
                end else if (w_shape.hold) begin
                    r_env_up    <= r_env_up ^ w_shape.alt;
                    r_env_state <= ENV_HOLD;
                end else if (w_shape.alt) begin
                    r_env_pos <= '0;
                    r_env_up  <= ~r_env_up;
                end else begin
                    r_env_pos <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            ch_a <= '0;
            ch_b <= '0;
            ch_c <= '0;
        end else begin
            ch_a <= psg_chan_level(w_tone_a, r_lfsr[0], r_regs[PSG_R_MIXER][0], r_regs[PSG_R_MIXER][3],
                                   r_regs[PSG_R_AMP_A][4:0], w_env_lvl);
            ch_b <= psg_chan_level(w_tone_b, r_lfsr[0], r_regs[PSG_R_MIXER][1], r_regs[PSG_R_MIXER][4],
                                   r_regs[PSG_R_AMP_B][4:0], w_env_lvl);
            ch_c <= psg_chan_level(w_tone_c, r_lfsr[0], r_regs[PSG_R_MIXER][2], r_regs[PSG_R_MIXER][5],
                                   r_regs[PSG_R_AMP_C][4:0], w_env_lvl);
        end
    end

endmodule

// File: doc/ay_psg.md
# ay_psg

Internal AY-3-8912-compatible PSG: the responder end of the BC1/BDIR bus. It decodes the BDIR/BC1 bus cycles generated by the CPU-side AY bus logic, holds the 16-register file and returns read data. It also runs three tone generators, one noise generator and one envelope generator, and outputs per-channel 4-bit amplitude codes for the DAC/mixer stage.

## Interface
- No parameters.
- clk28  in  1  system clock, 28 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- ck35  in  1  one-clk28 strobe at 3.5 MHz; PSG timebase enable.
- bdir  in  1  bus direction, registered copy from the CPU bus side.
- bc1  in  1  bus control 1, registered copy.
- d  in  8  CPU data bus for writes and address latch.
- q  out  8  read data.
- ch_a, ch_b, ch_c  out  4 each  channel amplitude codes.

## Operation
- Bus decode, sampled every clk28, with {bdir,bc1}:
  - 00: idle.
  - 01: read.
  - 10: write.
  - 11: latch address.
- Address latch:
  - addr <= d[3:0].
  - sel <= (d[7:4]==0).
  - Writes and reads while sel=0 are ignored.
- Write: reg[addr] <= d masked to the implemented bits:
  - R1/R3/R5: [3:0].
  - R6: [4:0].
  - R8–R10: [4:0].
  - R13: [3:0].
  - R14/R15: 8 bits.
  - Other registers: 8 bits.
- Read:
  - With sel=1, q <= masked reg[addr], unused bits 0.
  - Otherwise q <= 8'hFF.
  - q holds 8'hFF whenever the bus is not in a read cycle.
- Prescaler: a 4-bit counter on ck35 gives tick8 (clk/8, every 16 ck35), and tick16 on every second tick8.
- Tone (x3), 12-bit period TP = {R1,R0} etc.:
  - Counter advances on tick8.
  - When counter+1 >= max(TP,1): counter <= 0 and the square output toggles.
- Noise:
  - 5-bit period R6 (0 treated as 1), counter advances on tick16.
  - On wrap, the 17-bit LFSR shifts with new bit = lfsr[0]^lfsr[3]; noise output = lfsr[0].
- Mixer (R7):
  - gate_x = (tone_x | R7[x]) & (noise | R7[3+x]).
  - R7[7:6] are storage only.
- Amplitude: level = R8/9/A[4] ? env : R8/9/A[3:0]; ch_x = gate_x ? level : 0.
- Envelope:
  - 16-bit period {R12,R11} (0 treated as 1), counter advances on tick16.
  - Each wrap steps a 4-bit position.
  - R13 bits are CONT, ATT, ALT, HOLD.
  - State: running or holding; direction up when ATT=1.
- Envelope restart: on the first clk28 of a write cycle addressed to R13:
  - Position <= 0, direction <= ATT, state <= running, period counter <= 0.
  - This holds even if the written value is unchanged.
- Envelope end of a 16-step ramp:
  - CONT=0: hold at 0.
  - CONT=1, HOLD=1: hold at the final value, inverted if ALT=1.
  - CONT=1, HOLD=0, ALT=1: reverse direction.
  - Otherwise: wrap.
- Env output = direction up ? position : 15-position.

## Timing
- Reset values:
  - All registers 0, addr 0, sel 1.
  - q 8'hFF.
  - ch_a/b/c 0.
  - Tone outputs 0, counters 0.
  - LFSR 17'h1.
  - Envelope holding at 0.
- Register write is visible on q and on the generators 1 clk28 after the sampled write cycle.
- Read latency: q is valid 1 clk28 after {bdir,bc1}=01 is sampled.
- ch_x are registered and update 1 clk28 after the generator state changes.
- Period change mid-count: the new value applies at the next compare. A counter already >= the new period wraps on the next tick.
- Simultaneous R13 write and envelope tick: restart wins and the tick is dropped.
- Reset is asynchronous and may occur mid-bus-cycle. The bus cycle in progress at deassertion is ignored until {bdir,bc1} passes through 00.

## Structure
- The `common` package holds:
  - Register index localparams (PSG_R_MIXER=7, PSG_R_ENV_SHAPE=13, …).
  - Per-register read-mask constant array.
  - Envelope state enum (ENV_RUN, ENV_HOLD).
- Sub-module `psg_tone`: 12-bit period counter plus square toggle, instantiated three times.
- Noise, envelope and the bus decoder stay inline.

## Test plan
- Address/write/read:
  - Latch 8'h00, write 8'hFF, latch 8'h00, read -> q=8'hFF.
  - Latch 8'h01, write 8'hFF, read -> q=8'h0F.
  - Latch 8'h10, read -> q=8'hFF; a write while latched at 8'h10 leaves R0 unchanged.
- Tone:
  - R0=1, R1=0, R7=8'h3E, R8=8'h0F -> ch_a toggles between 15 and 0 every 16 ck35 strobes.
  - With TP=0, behaviour is identical to TP=1.
- Noise: R7=8'h37, R6=0, R8=8'h0A -> ch_a ∈ {0,10} following the LFSR reference model for 1000 ticks.
- Envelope shapes with R11=1, R12=0, R8=8'h10:
  - Shape 8'h0E: triangle 0..15..0 continuous.
  - Shape 8'h09: 15..0 then held at 0.
  - Shape 8'h0D: 0..15 then held at 15.
- R13 rewrite mid-ramp -> position restarts at 0 on the next clk28.
- Reset asserted mid-tone -> all outputs 0 immediately, q=8'hFF, registers cleared.
